bo_datapath: RTL and testbench

//  Operative block (datapath) driven by the sequencing control FSM. It consumes control word
//  {m0,m1,m2,lx,ls,lh,h} each clock, holds X, H, S registers around one shared ALU, and

---
 rtl/bo_datapath_if.sv | 28 ++
 rtl/bo_datapath.sv | 130 +++++++++++++
 tb/tb_bo_datapath.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bo_datapath_if.sv
// Control word, operands and result of the bo_datapath operative block.
// The master side is the sequencing FSM (or bench); the slave side is the datapath.
interface bo_datapath_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] coef_c;
    logic [1:0]       m0;
    logic [1:0]       m1;
    logic [1:0]       m2;
    logic             lx;
    logic             ls;
    logic             lh;
    logic             h;
    logic [WIDTH-1:0] s_out;
    logic             done;
    logic             ovf;

    modport master (
        output x_in, coef_c, m0, m1, m2, lx, ls, lh, h,
        input  s_out, done, ovf
    );

    modport slave (
        input  x_in, coef_c, m0, m1, m2, lx, ls, lh, h,
        output s_out, done, ovf
    );
endinterface

// File: rtl/bo_datapath.sv
// X/H/S registers around one shared ALU; loads land 1 cycle after the sampling edge, done 1 cycle after a NOP.
// No backpressure: a control word is consumed every cycle. Sticky overflow flag only with BO_OVF_EN defined.
module bo_datapath #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    bo_datapath_if.slave bo
);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] h_q, h_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] opa, opb, alu_res;
    logic [WIDTH-1:0] prod_lo;
    logic             nop, any_ld;

    always_comb begin
        opa = '0;
        case (bo.m0)
            2'b01:   opa = x_q;
            2'b10:   opa = s_q;
            2'b11:   opa = h_q;
            default: opa = '0;
        endcase
    end

    always_comb begin
        opb = '0;
        case (bo.m1)
            2'b00:   opb = h_q;
            2'b01:   opb = x_q;
            2'b10:   opb = bo.coef_c;
            default: opb = s_q;
        endcase
    end

`ifdef BO_OVF_EN
    logic [WIDTH-1:0] prod_hi;
    assign {prod_hi, prod_lo} = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};
`else
    assign prod_lo = opa * opb;
`endif

    always_comb begin
        alu_res = '0;
        case (bo.m2)
            2'b00:   alu_res = opa + opb;
            2'b01:   alu_res = opa - opb;
            2'b10:   alu_res = prod_lo;
            default: alu_res = opa;
        endcase
    end

    assign nop    = (bo.m0 == 2'b00) && (bo.m1 == 2'b00) && (bo.m2 == 2'b00)
                    && !bo.lx && !bo.ls && !bo.lh;
    assign any_ld = bo.ls | bo.lh;

    // All loads see pre-edge register values; lx clears busy even when ls/lh are also set.
    always_comb begin
        x_d    = bo.lx ? bo.x_in : x_q;
        h_d    = bo.lh ? alu_res : h_q;
        s_d    = s_q;
        if (bo.ls) begin
            s_d = bo.h ? alu_res : (alu_res >> 1);
        end
        busy_d = busy_q;
        if (bo.lx || nop) begin
            busy_d = 1'b0;
        end else if (any_ld) begin
            busy_d = 1'b1;
        end
        done_d = nop && busy_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            h_q    <= '0;
            s_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            h_q    <= h_d;
            s_q    <= s_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bo.s_out = s_q;
    assign bo.done  = done_q;

`ifdef BO_OVF_EN
    logic ovf_q, ovf_d, alu_ovf;

    always_comb begin
        alu_ovf = 1'b0;
        case (bo.m2)
            2'b00:   alu_ovf = (alu_res < opa);
            2'b01:   alu_ovf = (opa < opb);
            2'b10:   alu_ovf = |prod_hi;
            default: alu_ovf = 1'b0;
        endcase
        ovf_d = ovf_q;
        if (bo.lx) begin
            ovf_d = 1'b0;
        end else if (any_ld && alu_ovf) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bo.ovf = ovf_q;
`else
    assign bo.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bo_datapath.sv
// Directed-vector bench for bo_datapath (WIDTH=8); expected ovf follows BO_OVF_EN.
module tb_bo_datapath;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    logic ovf_en;

    bo_datapath_if #(.WIDTH(WIDTH)) bo ();

    bo_datapath #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bo  (bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Apply one control word, let one edge pass, return 1 time unit after it.
    task automatic step(input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2,
                        input logic lx, input logic ls, input logic lh, input logic h);
        bo.m0 = m0;
        bo.m1 = m1;
        bo.m2 = m2;
        bo.lx = lx;
        bo.ls = ls;
        bo.lh = lh;
        bo.h  = h;
        @(posedge clk);
        #1;
    endtask

    task automatic nop_step();
        step(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
`ifdef BO_OVF_EN
        ovf_en = 1'b1;
`else
        ovf_en = 1'b0;
`endif
        rst       = 1'b1;
        bo.x_in   = '0;
        bo.coef_c = '0;
        bo.m0 = 2'b00; bo.m1 = 2'b00; bo.m2 = 2'b00;
        bo.lx = 1'b0;  bo.ls = 1'b0;  bo.lh = 1'b0; bo.h = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_out", 32'(bo.s_out), 32'h0);
        chk("rst_done",  32'(bo.done),  32'h0);
        chk("rst_ovf",   32'(bo.ovf),   32'h0);
        #3 rst = 1'b0;

        // Build some state, then reset mid-clock with a sequence pending.
        bo.x_in = 8'd7;
        step(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(2'b01, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("pre_rst_s", 32'(bo.s_out), 32'd7);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_s",    32'(bo.s_out), 32'h0);
        chk("async_rst_done", 32'(bo.done),  32'h0);
        chk("async_rst_ovf",  32'(bo.ovf),   32'h0);
        #1 rst = 1'b0;
        nop_step();
        chk("rst_no_done", 32'(bo.done), 32'h0);
        step(2'b01, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst_x_zero", 32'(bo.s_out), 32'h0);
        step(2'b11, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst_h_zero", 32'(bo.s_out), 32'h0);
        nop_step();

        // X=5, H=X*3=15, S=H+X with and without shift, then NOP handshake.
        bo.x_in   = 8'd5;
        bo.coef_c = 8'd3;
        step(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
        step(2'b11, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("add_h1",   32'(bo.s_out), 32'd20);
        chk("busy_nodone", 32'(bo.done), 32'h0);
        step(2'b11, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("add_h0",   32'(bo.s_out), 32'd10);
        nop_step();
        chk("done_pulse", 32'(bo.done), 32'h1);
        chk("done_hold_s", 32'(bo.s_out), 32'd10);
        nop_step();
        chk("done_2nd_nop", 32'(bo.done), 32'h0);

        // 0 - X with X=1 wraps to all ones and borrows.
        bo.x_in = 8'd1;
        step(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("sub_wrap", 32'(bo.s_out), 32'hFF);
        chk("sub_ovf",  32'(bo.ovf),   32'(ovf_en));
        nop_step();
        chk("sub_done", 32'(bo.done), 32'h1);
        chk("ovf_sticky", 32'(bo.ovf), 32'(ovf_en));
        bo.x_in = 8'd2;
        step(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovf_lx_clr", 32'(bo.ovf), 32'h0);

        // lx with lh: H takes old X=2, X takes 9, busy stays clear.
        bo.x_in = 8'd9;
        step(2'b01, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("lxlh_done", 32'(bo.done), 32'h0);
        nop_step();
        chk("lxlh_nop_done", 32'(bo.done), 32'h0);
        step(2'b11, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("lxlh_h", 32'(bo.s_out), 32'd2);
        step(2'b01, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("lxlh_x", 32'(bo.s_out), 32'd9);
        step(2'b01, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("shift_odd", 32'(bo.s_out), 32'd4);
        step(2'b01, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("sub_x_s", 32'(bo.s_out), 32'd5);
        chk("sub_no_ovf", 32'(bo.ovf), 32'h0);
        step(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("no_load_hold", 32'(bo.s_out), 32'd5);
        chk("no_load_done", 32'(bo.done),  32'h0);
        nop_step();
        chk("late_done", 32'(bo.done), 32'h1);

        // 9*200 = 0x708: low byte kept, upper bits flag overflow.
        bo.coef_c = 8'd200;
        step(2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mul_ovf", 32'(bo.ovf), 32'(ovf_en));
        step(2'b11, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("mul_lo", 32'(bo.s_out), 32'h08);

        // Carry with lx in the same cycle: lx clear wins.
        bo.x_in   = 8'd3;
        bo.coef_c = 8'd250;
        step(2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("carry_sum", 32'(bo.s_out), 32'd2);
        chk("lx_wins",   32'(bo.ovf),   32'h0);
        bo.coef_c = 8'd255;
        step(2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("carry_sum2", 32'(bo.s_out), 32'd1);
        chk("carry_ovf",  32'(bo.ovf),   32'(ovf_en));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
